dsp_alu_pipe: RTL and testbench
===============================

Name: dsp_alu_pipe

Overview:
Parametrised, pipelined arithmetic unit that replaces the fixed 2-bit add/sub/multiply ALU. It supports N-bit operands, signed or unsigned mode, and four operations: multiply, add, subtract and multiply-accumulate. Operands enter and results leave through valid/ready handshakes, so the block can sit between a stream source and a consumer that may stall. Multiply maps to a DSP slice and the add/sub paths share the post-adder.

Parameters:
WIDTH, 8, operand width in bits (2..18).
GUARD, 4, accumulator guard bits above the 2*WIDTH product.
SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands.
(derived) ACC_W = 2*WIDTH+GUARD, width of the result and the accumulator.

Ports:
i_clk  in  1  clock.
i_rst_n  in  1  reset. Asynchronous assert, active-low.
i_a  in  WIDTH  operand A.
i_b  in  WIDTH  operand B.
i_select  in  2  operation: 00 = A*B, 01 = A+B, 10 = A-B, 11 = ACC+A*B (MAC).
i_clear  in  1  per-transaction flag; in MAC mode the accumulator is reloaded instead of added to.
i_valid  in  1  input transaction valid.
o_ready  out  1  block can accept an input this cycle.
o_result  out  ACC_W  result.
o_valid  out  1  o_result is valid.
i_ready  in  1  consumer accepts the result.
o_acc_ovf  out  1  sticky accumulator overflow flag.

Behaviour:
- Reset and clock: one clock, i_clk. Reset is i_rst_n, asynchronous and active-low.
- Values on reset: all stage valid bits = 0, accumulator = 0, o_result = 0, o_valid = 0, o_acc_ovf = 0.
- Reset mid-operation: in-flight transactions are discarded and never presented.
- Pipeline structure: three register stages.
  - S1: register operands, select and clear.
  - S2: product and sum/difference.
  - S3: accumulate and output register.
- Advance rule: advance = !o_valid | i_ready.
  - o_ready = advance. This is combinational from i_ready and o_valid.
  - All stages shift together when advance = 1.
  - When advance = 0, every stage holds, including o_result and o_valid.
- Input acceptance: a transaction is accepted when i_valid & o_ready. Bubbles propagate as valid = 0.
- Latency and throughput: with no stall, o_valid rises 3 cycles after the accepting edge. Throughput is 1 transaction per cycle.
- Ordering: results leave strictly in input order. No transaction is dropped or duplicated.
- Width rules: operands are sign-extended (SIGNED = 1) or zero-extended (SIGNED = 0) to ACC_W before any operation.
  - MUL: full 2*WIDTH product, extended to ACC_W.
  - ADD/SUB: computed in ACC_W. An unsigned SUB with B > A yields the ACC_W two's-complement value and sets no flag.
- MAC, evaluated in S3 only when the stage advances:
  - i_clear = 1: acc_next = product.
  - i_clear = 0: acc_next = acc + product, modulo 2^ACC_W.
  - o_result = acc_next.
- Accumulator isolation: non-MAC operations never read or modify the accumulator.
- i_clear outside MAC: ignored.
- o_acc_ovf set condition (MAC with i_clear = 0):
  - unsigned: carry out of bit ACC_W-1;
  - signed: both addends have the same sign and the sum has a different sign.
- o_acc_ovf clearing:
  - once set, it stays set until a MAC with i_clear = 1 reaches S3, or until reset;
  - the clearing MAC's own reload never sets it.
- Back-to-back MACs with no stall accumulate in consecutive cycles; no hazard stall is needed.
- Stall while full: i_valid held high while o_ready = 0 is not accepted. The source must hold its data.

Test Plan:
1. Unsigned multiply (WIDTH=8, SIGNED=0): A=255, B=255, select=00 -> o_result=0x0FE01 with o_valid 3 cycles after acceptance. Then 3+5 (01) -> 8, 3-5 (10) -> 0xFFFFE on a 20-bit result.
2. Signed mode (SIGNED=1): -128*-128 -> 16384; -3*5 -> 0xFFFF1 (-15); 127+127 -> 254; o_acc_ovf stays 0.
3. MAC sequence: (10,10,clear=1), (20,3,0), (5,5,0) back-to-back -> 100, 160, 185. An interleaved MUL 2*2 -> 4 leaves the next MAC continuing from 185.
4. Backpressure:
   - stimulus: stream 6 transactions, then drive i_ready=0 for 4 cycles with the pipeline full;
   - required: o_ready=0 and o_result/o_valid held stable during the stall;
   - required: all 6 results are delivered in order, with no loss or duplication.
5. Overflow:
   - stimulus: MAC 255*255, first with clear=1, then 16 more with clear=0;
   - required: the 16th result is 1040400 with o_acc_ovf=0;
   - required: the 17th result is 56849 with o_acc_ovf=1, and the flag stays 1 through subsequent MULs;
   - required: a MAC with clear=1 returns the flag to 0.
6. Asynchronous reset: assert i_rst_n=0 mid-cycle with 3 transactions in flight -> immediately o_valid=0, o_result=0, o_acc_ovf=0. After release, the first new MAC without clear accumulates from 0.

Source files
------------

// File: rtl/dsp_alu_pipe.sv
// Three-stage pipelined multiply / add / subtract / multiply-accumulate unit with
// valid/ready handshakes on both sides and a sticky accumulator overflow flag.
module dsp_alu_pipe #(
  parameter int WIDTH  = 8,     // operand width, 2..18
  parameter int GUARD  = 4,     // accumulator guard bits above the full product
  parameter bit SIGNED = 1'b0,  // 1: two's-complement operands
  localparam int ACC_W = 2*WIDTH + GUARD
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_select,
  input  logic             i_clear,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [ACC_W-1:0] o_result,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_acc_ovf
);

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_MAC = 2'b11
  } op_e;

  function automatic logic signed [ACC_W-1:0] ext(input logic [WIDTH-1:0] v);
    logic fill;
    fill = SIGNED && v[WIDTH-1];
    return {{(ACC_W-WIDTH){fill}}, v};
  endfunction

  // Unsigned: carry out of the top bit. Signed: like-signed addends, differently signed sum.
  function automatic logic mac_ovf(input logic signed [ACC_W-1:0] x,
                                   input logic signed [ACC_W-1:0] y);
    logic [ACC_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (SIGNED)
      return (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
    else
      return s[ACC_W];
  endfunction

  logic                    advance;
  logic                    vld_p0, vld_p1;
  logic signed [ACC_W-1:0] a_p0, b_p0;
  op_e                     sel_p0, sel_p1;
  logic                    clr_p0, clr_p1;
  logic signed [ACC_W-1:0] prod_p1, sum_p1;
  logic signed [ACC_W-1:0] acc, acc_next;
  logic                    ovf_hit;

  assign advance = !o_valid || i_ready;
  assign o_ready = advance;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (advance) begin
      vld_p0 <= i_valid;
      vld_p1 <= vld_p0;
    end
  end

  // S1: register extended operands and control
  always_ff @(posedge i_clk) begin
    if (advance) begin
      a_p0   <= ext(i_a);
      b_p0   <= ext(i_b);
      sel_p0 <= op_e'(i_select);
      clr_p0 <= i_clear;
    end
  end

  // S2: product and shared sum/difference
  always_ff @(posedge i_clk) begin
    if (advance) begin
      prod_p1 <= a_p0 * b_p0;
      sum_p1  <= (sel_p0 == OP_SUB) ? (a_p0 - b_p0) : (a_p0 + b_p0);
      sel_p1  <= sel_p0;
      clr_p1  <= clr_p0;
    end
  end

  always_comb begin
    acc_next = clr_p1 ? prod_p1 : (acc + prod_p1);
    ovf_hit  = !clr_p1 && mac_ovf(acc, prod_p1);
  end

  // S3: accumulate and output register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_result  <= '0;
      acc       <= '0;
      o_acc_ovf <= 1'b0;
    end else if (advance) begin
      o_valid <= vld_p1;
      if (vld_p1) begin
        case (sel_p1)
          OP_MUL:         o_result <= prod_p1;
          OP_ADD, OP_SUB: o_result <= sum_p1;
          default: begin
            o_result <= acc_next;
            acc      <= acc_next;
            if (clr_p1)
              o_acc_ovf <= 1'b0;
            else if (ovf_hit)
              o_acc_ovf <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsp_alu_pipe.sv
// Directed bench for dsp_alu_pipe: an unsigned and a signed instance share one stimulus
// stream; a vector table plus hand sequences for stall, overflow and reset.
module tb_dsp_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic [1:0]  sel = '0;
  logic        clr = 1'b0, vld = 1'b0, rdy = 1'b1;

  logic        u_ready, u_valid, u_ovf;
  logic [19:0] u_result;
  logic        s_ready, s_valid, s_ovf;
  logic [19:0] s_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dsp_alu_pipe #(.WIDTH(8), .GUARD(4), .SIGNED(1'b0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_select(sel), .i_clear(clr),
    .i_valid(vld), .o_ready(u_ready), .o_result(u_result), .o_valid(u_valid),
    .i_ready(rdy), .o_acc_ovf(u_ovf)
  );

  dsp_alu_pipe #(.WIDTH(8), .GUARD(4), .SIGNED(1'b1)) u_sdut (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_select(sel), .i_clear(clr),
    .i_valid(vld), .o_ready(s_ready), .o_result(s_result), .o_valid(s_valid),
    .i_ready(rdy), .o_acc_ovf(s_ovf)
  );

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  sel;
    logic        clr;
    logic [19:0] exp_u;
    logic        chk_s;
    logic [19:0] exp_s;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];
  logic mon_on = 1'b0;
  int   out_idx = 0;

  always @(negedge clk) begin
    if (mon_on && u_valid && rdy) begin
      if (out_idx < NV) begin
        check($sformatf("tbl%0d_u", out_idx), 32'(u_result), 32'(tbl[out_idx].exp_u));
        if (tbl[out_idx].chk_s)
          check($sformatf("tbl%0d_s", out_idx), 32'(s_result), 32'(tbl[out_idx].exp_s));
      end else begin
        check("tbl_extra_out", 32'(out_idx), 32'(NV - 1));
      end
      out_idx++;
    end
  end

  task automatic do_tx(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] tsel,
                       input logic tclr, output logic [19:0] res, output logic ovf,
                       output int lat);
    @(negedge clk);
    a = ta; b = tb; sel = tsel; clr = tclr; vld = 1'b1; rdy = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    lat = 1;
    while (!u_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    res = u_result;
    ovf = u_ovf;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] r;
    logic        o;
    int          lat;
    int          sent, recv, cyc, t;
    int          exp_bp [6];

    tbl[0]  = '{8'd255, 8'd255, 2'd0, 1'b0, 20'h0FE01, 1'b1, 20'h00001};
    tbl[1]  = '{8'd3,   8'd5,   2'd1, 1'b0, 20'h00008, 1'b1, 20'h00008};
    tbl[2]  = '{8'd3,   8'd5,   2'd2, 1'b0, 20'hFFFFE, 1'b1, 20'hFFFFE};
    tbl[3]  = '{8'd128, 8'd128, 2'd0, 1'b0, 20'h04000, 1'b1, 20'h04000};
    tbl[4]  = '{8'd253, 8'd5,   2'd0, 1'b0, 20'h004F1, 1'b1, 20'hFFFF1};
    tbl[5]  = '{8'd127, 8'd127, 2'd1, 1'b0, 20'd254,   1'b1, 20'd254};
    tbl[6]  = '{8'd10,  8'd10,  2'd3, 1'b1, 20'd100,   1'b1, 20'd100};
    tbl[7]  = '{8'd20,  8'd3,   2'd3, 1'b0, 20'd160,   1'b1, 20'd160};
    tbl[8]  = '{8'd5,   8'd5,   2'd3, 1'b0, 20'd185,   1'b1, 20'd185};
    tbl[9]  = '{8'd2,   8'd2,   2'd0, 1'b0, 20'd4,     1'b1, 20'd4};
    tbl[10] = '{8'd1,   8'd1,   2'd3, 1'b0, 20'd186,   1'b1, 20'd186};
    tbl[11] = '{8'd255, 8'd255, 2'd1, 1'b0, 20'd510,   1'b1, 20'hFFFFE};
    tbl[12] = '{8'd0,   8'd255, 2'd2, 1'b0, 20'hFFF01, 1'b1, 20'h00001};
    tbl[13] = '{8'd1,   8'd2,   2'd1, 1'b1, 20'd3,     1'b1, 20'd3};
    tbl[14] = '{8'd0,   8'd0,   2'd3, 1'b0, 20'd186,   1'b1, 20'd186};
    exp_bp = '{7, 14, 21, 28, 35, 42};

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(u_valid), 32'd0);
    check("rst_result", 32'(u_result), 32'd0);
    check("rst_ovf", 32'(u_ovf), 32'd0);
    check("rst_ready", 32'(u_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // vector table, streamed back-to-back
    mon_on = 1'b1;
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      a = tbl[k].a; b = tbl[k].b; sel = tbl[k].sel; clr = tbl[k].clr; vld = 1'b1;
    end
    @(negedge clk);
    vld = 1'b0;
    t = 0;
    while (out_idx < NV && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("tbl_count", 32'(out_idx), 32'(NV));
    @(negedge clk);
    #1;
    mon_on = 1'b0;
    check("tbl_drained", 32'(u_valid), 32'd0);
    check("tbl_u_ovf", 32'(u_ovf), 32'd0);
    check("tbl_s_ovf", 32'(s_ovf), 32'd0);

    // backpressure: 6 MULs, consumer stalls 4 cycles with the pipeline full
    sent = 0; recv = 0; cyc = 0;
    while (recv < 6 && cyc < 40) begin
      @(negedge clk);
      rdy = !(cyc >= 4 && cyc < 8);
      if (sent < 6) begin
        a = 8'(sent + 1); b = 8'd7; sel = 2'd0; clr = 1'b0; vld = 1'b1;
      end else begin
        vld = 1'b0;
      end
      #1;
      if (!rdy) begin
        check("bp_ready_low", 32'(u_ready), 32'd0);
        check("bp_hold_valid", 32'(u_valid), 32'd1);
        check("bp_hold_result", 32'(u_result), 32'(exp_bp[recv]));
      end
      if (vld && u_ready) sent++;
      if (u_valid && rdy) begin
        check($sformatf("bp_res%0d", recv), 32'(u_result), 32'(exp_bp[recv]));
        recv++;
      end
      cyc++;
    end
    check("bp_recv", 32'(recv), 32'd6);
    check("bp_sent", 32'(sent), 32'd6);
    vld = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    #1;
    check("bp_no_dup", 32'(u_valid), 32'd0);

    // accumulator overflow
    do_tx(8'd255, 8'd255, 2'd3, 1'b1, r, o, lat);
    check("mac_latency", 32'(lat), 32'd3);
    check("ovf_first", 32'(r), 32'd65025);
    for (int k = 2; k <= 17; k++) begin
      do_tx(8'd255, 8'd255, 2'd3, 1'b0, r, o, lat);
      if (k == 16) begin
        check("ovf_16_res", 32'(r), 32'd1040400);
        check("ovf_16_flag", 32'(o), 32'd0);
      end
      if (k == 17) begin
        check("ovf_17_res", 32'(r), 32'd56849);
        check("ovf_17_flag", 32'(o), 32'd1);
      end
    end
    do_tx(8'd3, 8'd3, 2'd0, 1'b0, r, o, lat);
    check("ovf_mul_res", 32'(r), 32'd9);
    check("ovf_sticky_mul", 32'(o), 32'd1);
    do_tx(8'd2, 8'd5, 2'd1, 1'b0, r, o, lat);
    check("ovf_sticky_add", 32'(o), 32'd1);
    do_tx(8'd1, 8'd1, 2'd3, 1'b1, r, o, lat);
    check("ovf_clear_res", 32'(r), 32'd1);
    check("ovf_cleared", 32'(o), 32'd0);
    for (int k = 0; k < 17; k++)
      do_tx(8'd255, 8'd255, 2'd3, 1'b0, r, o, lat);
    check("ovf_reset_again", 32'(o), 32'd1);
    check("s_ovf_quiet", 32'(s_ovf), 32'd0);

    // asynchronous reset with three MACs in flight
    @(negedge clk);
    a = 8'd4; b = 8'd4; sel = 2'd3; clr = 1'b0; vld = 1'b1;
    @(negedge clk);
    a = 8'd5;
    @(negedge clk);
    a = 8'd6;
    @(negedge clk);
    vld = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(u_valid), 32'd0);
    check("arst_result", 32'(u_result), 32'd0);
    check("arst_ovf", 32'(u_ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_tx(8'd3, 8'd4, 2'd3, 1'b0, r, o, lat);
    check("arst_latency", 32'(lat), 32'd3);
    check("arst_mac_from0", 32'(r), 32'd12);
    check("arst_mac_ovf", 32'(o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
